branch_predict_resolve: RTL

BRANCH_PREDICT_RESOLVE -- requirements
Module: branch_predict_resolve

---
 rtl/bp_pkg.sv | 42 ++++
 rtl/branch_cond_eval.sv | 37 +++
 rtl/branch_predict_resolve.sv | 105 ++++++++++
 3 files changed

// File: rtl/bp_pkg.sv
// Shared encodings for the branch predictor/resolver: branch-type bits,
// ALU flag positions, 2-bit counter states and the saturating update rule.
`default_nettype none

package bp_pkg;

  localparam int BR_W    = 6;
  localparam int BR_BEQ  = 5;
  localparam int BR_BNE  = 4;
  localparam int BR_BLT  = 3;
  localparam int BR_BGE  = 2;
  localparam int BR_BLTU = 1;
  localparam int BR_BGEU = 0;

  localparam int FLAG_W = 4;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_SNT = 2'b00;
  localparam ctr_t CTR_WNT = 2'b01;
  localparam ctr_t CTR_WT  = 2'b10;
  localparam ctr_t CTR_ST  = 2'b11;

  // Counter moves one step toward the outcome and sticks at either end.
  function automatic ctr_t ctr_next(input ctr_t ctr, input logic taken);
    ctr_t nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != CTR_ST) nxt = ctr + 2'd1;
    end else begin
      if (ctr != CTR_SNT) nxt = ctr - 2'd1;
    end
    return nxt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/branch_cond_eval.sv
// Combinational branch/jump outcome from one-hot (or multi-hot) type and {N,Z,C,V}.
`default_nettype none

module branch_cond_eval
  import bp_pkg::*;
(
  input  logic              valid,
  input  logic [BR_W-1:0]   branch,
  input  logic              jump,
  input  logic [FLAG_W-1:0] flags,
  output logic              taken
);

  logic n, z, c, v;
  logic signed_lt;
  logic cond_hit;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  // C set means no borrow, i.e. unsigned a >= b.
  assign signed_lt = n ^ v;

  assign cond_hit = (branch[BR_BEQ]  &  z)
                  | (branch[BR_BNE]  & ~z)
                  | (branch[BR_BLT]  &  signed_lt)
                  | (branch[BR_BGE]  & ~signed_lt)
                  | (branch[BR_BLTU] & ~c)
                  | (branch[BR_BGEU] &  c);

  assign taken = valid & (jump | cond_hit);

endmodule

`default_nettype wire

// File: rtl/branch_predict_resolve.sv
// Bimodal 2-bit-counter predictor with execute-stage resolution and redirect.
// Optional performance counters are built only when BP_STATS_EN is defined.
`default_nettype none

module branch_predict_resolve
  import bp_pkg::*;
#(
  parameter int   XLEN        = 32,
  parameter int   BHT_ENTRIES = 64,
  parameter ctr_t CTR_INIT    = 2'b01
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   if_pc,
  output logic              pred_taken,
  input  logic              ex_valid,
  input  logic              ex_stall,
  input  logic [XLEN-1:0]   ex_pc,
  input  logic [BR_W-1:0]   ex_branch,
  input  logic              ex_jump,
  input  logic [FLAG_W-1:0] ex_alu_flags,
  input  logic              ex_pred_taken,
  output logic              ex_taken,
  output logic              redirect,
  output logic              redirect_taken,
  output logic [31:0]       stat_branches,
  output logic [31:0]       stat_mispredicts
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  ctr_t             bht [0:BHT_ENTRIES-1];
  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic             fire;
  logic             do_update;
  logic             mispredict;
  logic             unused_pc_bits;

  // Word-aligned index; upper PC bits alias freely.
  assign if_idx = if_pc[IDX_W+1:2];
  assign ex_idx = ex_pc[IDX_W+1:2];

  assign unused_pc_bits = ^{if_pc, ex_pc};

  // Read is the pre-update value even when the same entry is being written.
  assign pred_taken = bht[if_idx][1];

  branch_cond_eval u_cond (
    .valid  (ex_valid),
    .branch (ex_branch),
    .jump   (ex_jump),
    .flags  (ex_alu_flags),
    .taken  (ex_taken)
  );

  assign fire       = ex_valid & ~ex_stall;
  assign do_update  = fire & (|ex_branch);
  assign mispredict = fire & (ex_taken ^ ex_pred_taken);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht[i] <= CTR_INIT;
      end
    end else if (do_update) begin
      bht[ex_idx] <= ctr_next(bht[ex_idx], ex_taken);
    end
  end

  // A stalled mispredict simply waits: it fires once the stall releases.
  always_ff @(posedge clk) begin
    if (rst) begin
      redirect       <= 1'b0;
      redirect_taken <= 1'b0;
    end else begin
      redirect       <= mispredict;
      redirect_taken <= ex_taken;
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] branch_cnt;
  logic [31:0] mispredict_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt     <= 32'd0;
      mispredict_cnt <= 32'd0;
    end else begin
      if (fire)       branch_cnt     <= branch_cnt + 32'd1;
      if (mispredict) mispredict_cnt <= mispredict_cnt + 32'd1;
    end
  end

  assign stat_branches    = branch_cnt;
  assign stat_mispredicts = mispredict_cnt;
`else
  assign stat_branches    = 32'd0;
  assign stat_mispredicts = 32'd0;
`endif

endmodule

`default_nettype wire
